// File: rtl/warp_lsu_pkg.sv
// Shared types for the warp load/store unit: data word, warp pipeline state and
// per-lane LSU state.
package warp_lsu_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

    // A lane keeps the warp stalled while it has a request being formed or in flight.
    function automatic logic lsu_active(input lsu_state_t s);
        return (s == LSU_REQUESTING) || (s == LSU_WAITING);
    endfunction

endpackage

// File: rtl/warp_lsu_lane.sv
// One lane of the warp LSU: a four-state FSM that issues a single load or store
// per instruction and captures load data for write-back.
module lsu_lane
    import warp_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = warp_lsu_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  thread_enable,
    input  warp_state_t           warp_state,
    input  logic                  decoded_mem_read_enable,
    input  logic                  decoded_mem_write_enable,
    input  logic [DATA_WIDTH-1:0] rs1,
    input  logic [DATA_WIDTH-1:0] rs2,
    output logic                  mem_read_valid,
    output logic [DATA_WIDTH-1:0] mem_read_address,
    input  logic                  mem_read_ready,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_write_valid,
    output logic [DATA_WIDTH-1:0] mem_write_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_write_ready,
    output logic [DATA_WIDTH-1:0] lsu_out,
    output lsu_state_t            lsu_state
);

    // Latched at issue so a load+store decode resolves to a load for the whole transaction.
    logic is_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            lsu_state         <= LSU_IDLE;
            is_load           <= 1'b0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            lsu_out           <= '0;
        end else if (enable) begin
            case (lsu_state)
                LSU_IDLE: begin
                    if (thread_enable && (warp_state == WARP_REQUEST) &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        is_load   <= decoded_mem_read_enable;
                        lsu_state <= LSU_REQUESTING;
                    end
                end
                LSU_REQUESTING: begin
                    // Operands arrive from the register file one cycle after WARP_REQUEST.
                    if (is_load) begin
                        mem_read_address <= rs1;
                        mem_read_valid   <= 1'b1;
                    end else begin
                        mem_write_address <= rs1;
                        mem_write_data    <= rs2;
                        mem_write_valid   <= 1'b1;
                    end
                    lsu_state <= LSU_WAITING;
                end
                LSU_WAITING: begin
                    if (is_load) begin
                        if (mem_read_ready) begin
                            lsu_out        <= mem_read_data;
                            mem_read_valid <= 1'b0;
                            lsu_state      <= LSU_DONE;
                        end
                    end else if (mem_write_ready) begin
                        mem_write_valid <= 1'b0;
                        lsu_state       <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    if (warp_state == WARP_UPDATE) begin
                        lsu_state <= LSU_IDLE;
                    end
                end
                default: lsu_state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/warp_lsu.sv
// Per-warp load/store unit: one independent lane FSM per thread, with a combined
// busy flag that holds the warp scheduler in WARP_WAIT.
module warp_lsu
    import warp_lsu_pkg::*;
#(
    parameter int THREADS_PER_WARP = 32,
    parameter int DATA_WIDTH       = warp_lsu_pkg::DATA_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [THREADS_PER_WARP-1:0] thread_enable,
    input  warp_state_t                 warp_state,
    input  logic                        decoded_mem_read_enable,
    input  logic                        decoded_mem_write_enable,
    input  logic [DATA_WIDTH-1:0]       rs1               [THREADS_PER_WARP],
    input  logic [DATA_WIDTH-1:0]       rs2               [THREADS_PER_WARP],
    output logic [THREADS_PER_WARP-1:0] mem_read_valid,
    output logic [DATA_WIDTH-1:0]       mem_read_address  [THREADS_PER_WARP],
    input  logic [THREADS_PER_WARP-1:0] mem_read_ready,
    input  logic [DATA_WIDTH-1:0]       mem_read_data     [THREADS_PER_WARP],
    output logic [THREADS_PER_WARP-1:0] mem_write_valid,
    output logic [DATA_WIDTH-1:0]       mem_write_address [THREADS_PER_WARP],
    output logic [DATA_WIDTH-1:0]       mem_write_data    [THREADS_PER_WARP],
    input  logic [THREADS_PER_WARP-1:0] mem_write_ready,
    output logic [DATA_WIDTH-1:0]       lsu_out           [THREADS_PER_WARP],
    output lsu_state_t                  lsu_state         [THREADS_PER_WARP],
    output logic                        lsu_busy
);

    for (genvar i = 0; i < THREADS_PER_WARP; i++) begin : g_lane
        lsu_lane #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .clk                     (clk),
            .reset                   (reset),
            .enable                  (enable),
            .thread_enable           (thread_enable[i]),
            .warp_state              (warp_state),
            .decoded_mem_read_enable (decoded_mem_read_enable),
            .decoded_mem_write_enable(decoded_mem_write_enable),
            .rs1                     (rs1[i]),
            .rs2                     (rs2[i]),
            .mem_read_valid          (mem_read_valid[i]),
            .mem_read_address        (mem_read_address[i]),
            .mem_read_ready          (mem_read_ready[i]),
            .mem_read_data           (mem_read_data[i]),
            .mem_write_valid         (mem_write_valid[i]),
            .mem_write_address       (mem_write_address[i]),
            .mem_write_data          (mem_write_data[i]),
            .mem_write_ready         (mem_write_ready[i]),
            .lsu_out                 (lsu_out[i]),
            .lsu_state               (lsu_state[i])
        );
    end

    always_comb begin
        lsu_busy = 1'b0;
        for (int i = 0; i < THREADS_PER_WARP; i++) begin
            lsu_busy = lsu_busy | lsu_active(lsu_state[i]);
        end
    end

endmodule
